// File: rtl/mem_dual_sched_if.sv
// Requester-side and mem_dual-side signals of the dual-port memory scheduler.
// The slave view belongs to the scheduler; the master view to the clients and the memory.
interface mem_dual_sched_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int NREQ  = 4
);
  localparam int AW = $clog2(DEPTH);

  // req/we/addr/wdata are held until the same-cycle gnt; rvalid pulses one cycle after a read grant.
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [NREQ*WIDTH-1:0] rdata;

  logic [WIDTH-1:0]      mem_data_0;
  logic [WIDTH-1:0]      mem_data_1;
  logic [AW-1:0]         mem_address_0;
  logic [AW-1:0]         mem_address_1;
  logic                  mem_wren_0;
  logic                  mem_wren_1;
  logic [WIDTH-1:0]      mem_q_0;
  logic [WIDTH-1:0]      mem_q_1;

  modport master (
    output req, we, addr, wdata, mem_q_0, mem_q_1,
    input  gnt, rvalid, rdata,
    input  mem_data_0, mem_data_1, mem_address_0, mem_address_1, mem_wren_0, mem_wren_1
  );

  modport slave (
    input  req, we, addr, wdata, mem_q_0, mem_q_1,
    output gnt, rvalid, rdata,
    output mem_data_0, mem_data_1, mem_address_0, mem_address_1, mem_wren_0, mem_wren_1
  );
endinterface

// File: rtl/mem_dual_sched.sv
// Round-robin scheduler granting up to two non-conflicting accesses per cycle onto a
// two-port memory, with fixed one-cycle read return and a zero-fill sweep after reset/clear.
module mem_dual_sched #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int NREQ  = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    output logic             busy,
    output logic             dbg_state,
    mem_dual_sched_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam int CW  = AW + 1;

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]         clr_nxt1, clr_nxt2;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic                  tag0_v_q, tag0_v_d, tag1_v_q, tag1_v_d;
    logic [IW-1:0]         tag0_id_q, tag0_id_d, tag1_id_q, tag1_id_d;
    logic [NREQ*WIDTH-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]       rvalid_c;

    logic [AW-1:0]         a_arr [NREQ];
    logic [WIDTH-1:0]      w_arr [NREQ];
    logic [IW-1:0]         idx;
    logic                  g0_v, g1_v;
    logic [IW-1:0]         g0_id, g1_id;
    logic [NREQ-1:0]       gnt_c;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        logic [IW1-1:0] s;
        s = {1'b0, base} + IW1'(off);
        if (s >= IW1'(NREQ)) s = s - IW1'(NREQ);
        return s[IW-1:0];
    endfunction

    // Port 0 goes to the first requester from ptr; port 1 to the next one that cannot collide.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = bus.addr[i*AW +: AW];
            w_arr[i] = bus.wdata[i*WIDTH +: WIDTH];
        end
        gnt_c = '0;
        g0_v  = 1'b0;
        g1_v  = 1'b0;
        g0_id = '0;
        g1_id = '0;
        idx   = '0;
        if (state_q == S_RUN) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = wrap_add(ptr_q, off);
                if (bus.req[idx]) begin
                    if (!g0_v) begin
                        g0_v  = 1'b1;
                        g0_id = idx;
                    end else if (!g1_v && !((a_arr[idx] == a_arr[g0_id]) &&
                                            (bus.we[idx] || bus.we[g0_id]))) begin
                        g1_v  = 1'b1;
                        g1_id = idx;
                    end
                end
            end
        end
        if (g0_v) gnt_c[g0_id] = 1'b1;
        if (g1_v) gnt_c[g1_id] = 1'b1;
    end

    assign clr_nxt1 = clr_cnt_q + CW'(1);
    assign clr_nxt2 = clr_cnt_q + CW'(2);

    always_comb begin
        bus.mem_wren_0    = 1'b0;
        bus.mem_address_0 = '0;
        bus.mem_data_0    = '0;
        bus.mem_wren_1    = 1'b0;
        bus.mem_address_1 = '0;
        bus.mem_data_1    = '0;
        if (state_q == S_CLEAR) begin
            bus.mem_wren_0    = 1'b1;
            bus.mem_address_0 = clr_cnt_q[AW-1:0];
            bus.mem_wren_1    = (clr_nxt1 < CW'(DEPTH));
            bus.mem_address_1 = clr_nxt1[AW-1:0];
        end else begin
            if (g0_v) begin
                bus.mem_wren_0    = bus.we[g0_id];
                bus.mem_address_0 = a_arr[g0_id];
                bus.mem_data_0    = bus.we[g0_id] ? w_arr[g0_id] : '0;
            end
            if (g1_v) begin
                bus.mem_wren_1    = bus.we[g1_id];
                bus.mem_address_1 = a_arr[g1_id];
                bus.mem_data_1    = bus.we[g1_id] ? w_arr[g1_id] : '0;
            end
        end
    end

    // Grants are only possible in RUN, so the tags naturally stay empty while clearing.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        tag0_v_d  = g0_v && !bus.we[g0_id];
        tag0_id_d = g0_id;
        tag1_v_d  = g1_v && !bus.we[g1_id];
        tag1_id_d = g1_id;
        case (state_q)
            S_CLEAR: begin
                if (clr_nxt2 >= CW'(DEPTH)) begin
                    state_d   = S_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_nxt2;
                end
            end
            default: begin
                if (g1_v)      ptr_d = wrap_add(g1_id, 1);
                else if (g0_v) ptr_d = wrap_add(g0_id, 1);
                if (clear) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    // Returning read data is steered straight from mem_q; the slice is remembered so it holds.
    always_comb begin
        rvalid_c = '0;
        rdata_d  = rdata_q;
        for (int i = 0; i < NREQ; i++) begin
            if (tag0_v_q && (tag0_id_q == IW'(i))) begin
                rvalid_c[i]               = 1'b1;
                rdata_d[i*WIDTH +: WIDTH] = bus.mem_q_0;
            end
            if (tag1_v_q && (tag1_id_q == IW'(i))) begin
                rvalid_c[i]               = 1'b1;
                rdata_d[i*WIDTH +: WIDTH] = bus.mem_q_1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            ptr_q     <= '0;
            tag0_v_q  <= 1'b0;
            tag0_id_q <= '0;
            tag1_v_q  <= 1'b0;
            tag1_id_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            tag0_v_q  <= tag0_v_d;
            tag0_id_q <= tag0_id_d;
            tag1_v_q  <= tag1_v_d;
            tag1_id_q <= tag1_id_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rvalid_c;
    assign bus.rdata  = rdata_d;
    assign busy       = (state_q == S_CLEAR);
    assign dbg_state  = (state_q == S_RUN);

endmodule

// File: tb/tb_mem_dual_sched.sv
// Bench for mem_dual_sched: behavioural two-port memory, a cycle-level reference model of
// the scheduling rules, directed scenarios and a randomized traffic phase.
module tb_mem_dual_sched;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 64;
    localparam int NREQ    = 4;
    localparam int AW      = $clog2(DEPTH);
    localparam int IW      = $clog2(NREQ);
    localparam int CLR_CYC = (DEPTH + 1) / 2;

    logic clock;
    logic rst_n;
    logic clear;
    logic busy;
    logic dbg_state;

    mem_dual_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus ();

    mem_dual_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .clear     (clear),
        .busy      (busy),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    // clock/reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // two-port memory stand-in, registered read
    logic [WIDTH-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    always @(posedge clock) begin
        if (bus.mem_wren_0) mem[bus.mem_address_0] <= bus.mem_data_0;
        if (bus.mem_wren_1) mem[bus.mem_address_1] <= bus.mem_data_1;
        bus.mem_q_0 <= mem[bus.mem_address_0];
        bus.mem_q_1 <= mem[bus.mem_address_1];
    end

    // requester stimulus state
    logic [NREQ-1:0]  t_req, t_we;
    logic [AW-1:0]    t_addr  [NREQ];
    logic [WIDTH-1:0] t_wdata [NREQ];
    logic             t_clear;

    // reference model state
    logic [WIDTH-1:0]    shadow [DEPTH];
    logic [WIDTH-1:0]    exp_rdata [NREQ];
    logic [IW+WIDTH-1:0] exp_q[$];
    int                  exp_ptr;
    bit                  exp_busy;
    int                  clr_left;

    logic [NREQ-1:0]       obs_gnt, obs_rv;
    logic [NREQ*WIDTH-1:0] obs_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive();
        bus.req = t_req;
        bus.we  = t_we;
        for (int i = 0; i < NREQ; i++) begin
            bus.addr[i*AW +: AW]        = t_addr[i];
            bus.wdata[i*WIDTH +: WIDTH] = t_wdata[i];
        end
        clear = t_clear;
    endtask

    task automatic set_req(input int i, input bit w, input int a, input int d);
        t_req[i]   = 1'b1;
        t_we[i]    = w;
        t_addr[i]  = AW'(a);
        t_wdata[i] = WIDTH'(d);
    endtask

    task automatic model_reset();
        exp_ptr  = 0;
        exp_busy = 1'b1;
        clr_left = CLR_CYC;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) exp_rdata[i] = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    // scoreboard: one call per clock, sampled mid-cycle
    task automatic model_check();
        logic [NREQ-1:0]     exp_rv, exp_gnt;
        logic [IW+WIDTH-1:0] e;
        int                  order[$];
        int                  p0, p1, k, ip;
        obs_gnt   = bus.gnt;
        obs_rv    = bus.rvalid;
        obs_rdata = bus.rdata;
        check("busy", 32'(busy), 32'(exp_busy));
        exp_rv = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ip = int'(e[IW+WIDTH-1:WIDTH]);
            exp_rv[ip]    = 1'b1;
            exp_rdata[ip] = e[WIDTH-1:0];
        end
        check("rvalid", 32'(obs_rv), 32'(exp_rv));
        for (int i = 0; i < NREQ; i++)
            check("rdata", 32'(obs_rdata[i*WIDTH +: WIDTH]), 32'(exp_rdata[i]));
        if (exp_busy) begin
            k = CLR_CYC - clr_left;
            check("clr_gnt", 32'(obs_gnt), 0);
            check("clr_wren0", 32'(bus.mem_wren_0), 1);
            check("clr_addr0", 32'(bus.mem_address_0), 32'(2 * k));
            check("clr_data0", 32'(bus.mem_data_0), 0);
            check("clr_wren1", 32'(bus.mem_wren_1), 32'((2 * k + 1) < DEPTH));
            if ((2 * k + 1) < DEPTH) check("clr_addr1", 32'(bus.mem_address_1), 32'(2 * k + 1));
            clr_left--;
            if (clr_left == 0) exp_busy = 1'b0;
        end else begin
            for (int off = 0; off < NREQ; off++)
                if (t_req[(exp_ptr + off) % NREQ]) order.push_back((exp_ptr + off) % NREQ);
            p0 = -1;
            p1 = -1;
            if (order.size() > 0) p0 = order[0];
            for (int j = 1; j < order.size(); j++) begin
                if (p1 < 0 && !(t_addr[order[j]] == t_addr[p0] && (t_we[order[j]] || t_we[p0])))
                    p1 = order[j];
            end
            exp_gnt = '0;
            if (p0 >= 0) exp_gnt[p0] = 1'b1;
            if (p1 >= 0) exp_gnt[p1] = 1'b1;
            check("gnt", 32'(obs_gnt), 32'(exp_gnt));
            check("wren0", 32'(bus.mem_wren_0), (p0 >= 0) ? 32'(t_we[p0]) : 0);
            check("addr0", 32'(bus.mem_address_0), (p0 >= 0) ? 32'(t_addr[p0]) : 0);
            check("wren1", 32'(bus.mem_wren_1), (p1 >= 0) ? 32'(t_we[p1]) : 0);
            check("addr1", 32'(bus.mem_address_1), (p1 >= 0) ? 32'(t_addr[p1]) : 0);
            if (p0 >= 0 && t_we[p0]) check("data0", 32'(bus.mem_data_0), 32'(t_wdata[p0]));
            if (p1 >= 0 && t_we[p1]) check("data1", 32'(bus.mem_data_1), 32'(t_wdata[p1]));
            foreach (order[j]) begin
                ip = order[j];
                if ((ip == p0 || ip == p1) && !t_we[ip]) exp_q.push_back({IW'(ip), shadow[t_addr[ip]]});
            end
            if (p0 >= 0 && t_we[p0]) shadow[t_addr[p0]] = t_wdata[p0];
            if (p1 >= 0 && t_we[p1]) shadow[t_addr[p1]] = t_wdata[p1];
            if (p1 >= 0) exp_ptr = (p1 + 1) % NREQ;
            else if (p0 >= 0) exp_ptr = (p0 + 1) % NREQ;
            if (p0 >= 0) t_req[p0] = 1'b0;
            if (p1 >= 0) t_req[p1] = 1'b0;
            if (t_clear) begin
                exp_busy = 1'b1;
                clr_left = CLR_CYC;
                for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clock);
        model_check();
        t_clear = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        t_req   = '0;
        t_we    = '0;
        t_clear = 1'b0;
        drive();
        #1;
        check("rst_busy", 32'(busy), 1);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_addr0", 32'(bus.mem_address_0), 0);
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic busy_run(input int already, input string tag);
        int cnt;
        cnt = already;
        while (busy && cnt < 200) begin
            cycle();
            cnt++;
        end
        check(tag, cnt, CLR_CYC);
    endtask

    initial begin
        int guard;
        rst_n   = 1'b0;
        t_req   = '0;
        t_we    = '0;
        t_clear = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        model_reset();
        do_reset();
        busy_run(0, "t1_busy");

        // four readers at distinct addresses, re-armed as soon as granted
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NREQ; i++) if (!t_req[i]) set_req(i, 0, 16 + 4 * k + i, 0);
            if (k == 0) t_req = '1;
            cycle();
            check("t2_pair", 32'(obs_gnt), (k % 2) ? 32'h0000_000c : 32'h0000_0003);
            if (k > 0) check("t2_rv", 32'(obs_rv), (k % 2) ? 32'h0000_0003 : 32'h0000_000c);
        end
        cycle();
        check("t2_rv_last", 32'(obs_rv), 32'h0000_000c);
        check("t1_zero", 32'(obs_rdata[2*WIDTH +: WIDTH]), 0);

        // write collision on address 5
        set_req(0, 1, 5, 8'h3c);
        set_req(1, 1, 5, 8'h77);
        cycle();
        check("t3_first", 32'(obs_gnt), 32'h0000_0001);
        cycle();
        check("t3_second", 32'(obs_gnt), 32'h0000_0002);
        set_req(2, 0, 5, 0);
        cycle();
        cycle();
        check("t3_rv", 32'(obs_rv), 32'h0000_0004);
        check("t3_data", 32'(obs_rdata[2*WIDTH +: WIDTH]), 32'h77);

        // shared read of address 9
        set_req(0, 1, 9, 8'ha5);
        cycle();
        set_req(2, 0, 9, 0);
        set_req(3, 0, 9, 0);
        cycle();
        check("t4_gnt", 32'(obs_gnt), 32'h0000_000c);
        cycle();
        check("t4_rv", 32'(obs_rv), 32'h0000_000c);
        check("t4_d2", 32'(obs_rdata[2*WIDTH +: WIDTH]), 32'ha5);
        check("t4_d3", 32'(obs_rdata[3*WIDTH +: WIDTH]), 32'ha5);

        // clear alongside a read grant
        set_req(0, 0, 9, 0);
        t_clear = 1'b1;
        cycle();
        check("t5_gnt", 32'(obs_gnt), 32'h0000_0001);
        cycle();
        check("t5_rv", 32'(obs_rv), 32'h0000_0001);
        check("t5_data", 32'(obs_rdata[0 +: WIDTH]), 32'ha5);
        busy_run(1, "t5_busy");
        set_req(1, 0, 9, 0);
        cycle();
        cycle();
        check("t5_zero", 32'(obs_rdata[1*WIDTH +: WIDTH]), 0);

        // randomized traffic with occasional clears
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!t_req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 255));
            t_clear = ($urandom_range(0, 149) == 0);
            cycle();
        end
        guard = 0;
        while ((t_req != '0 || busy || exp_q.size() > 0) && guard < 200) begin
            cycle();
            guard++;
        end
        check("drain", 32'(guard < 200), 1);

        // reset in the middle of a clear sweep
        t_clear = 1'b1;
        cycle();
        repeat (10) cycle();
        check("t6_pre_addr", 32'(bus.mem_address_0), 20);
        do_reset();
        busy_run(0, "t6_busy");
        set_req(3, 0, 40, 0);
        cycle();
        cycle();
        check("t6_zero", 32'(obs_rdata[3*WIDTH +: WIDTH]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
